// File: rtl/fpmul_pipe.sv
// fpmul_pipe: 3-stage pipelined floating-point multiplier with a global-stall valid/ready handshake.
// Build option FPMUL_PIPE_RNE_EN selects round-to-nearest-even; without it the result is truncated.
module fpmul_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic [3:0]   out_flags
);
  localparam int STAGES = 3;
  localparam int EW2    = EXP_W + 2;
  localparam int MW1    = MAN_W + 1;
  localparam int PW     = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {K_FIN, K_NAN, K_INF, K_ZERO} kind_e;

  typedef struct packed {
    logic                  sign;
    kind_e                 kind;
    logic                  inv;
    logic signed [EW2-1:0] exp;
    logic [MW1-1:0]        ma;
    logic [MW1-1:0]        mb;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    kind_e                 kind;
    logic                  inv;
    logic signed [EW2-1:0] exp;
    logic [PW-1:0]         prod;
  } s2_t;

  logic [STAGES:1] vld_pipe_q;
  logic            advance;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    s_d, s_q;
  logic [3:0]      f_d, f_q;

  assign advance   = ~vld_pipe_q[STAGES] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_s     = s_q;
  assign out_flags = f_q;

  // Stage 1: unpack and classify; subnormals read as zero because exp==0.
  logic             sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) & (fa == '0);
  assign ib = (&eb) & (fb == '0);
  assign na = (&ea) & (fa != '0);
  assign nb = (&eb) & (fb != '0);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sa ^ sb;
    s1_d.inv  = (ia & zb) | (ib & za) | (na & ~fa[MAN_W-1]) | (nb & ~fb[MAN_W-1]);
    if (na | nb | (ia & zb) | (ib & za)) s1_d.kind = K_NAN;
    else if (ia | ib)                     s1_d.kind = K_INF;
    else if (za | zb)                     s1_d.kind = K_ZERO;
    else                                  s1_d.kind = K_FIN;
    s1_d.exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s1_d.ma  = {1'b1, fa};
    s1_d.mb  = {1'b1, fb};
  end

  // Stage 2: full-width mantissa product.
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.kind = s1_q.kind;
    s2_d.inv  = s1_q.inv;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = {{MW1{1'b0}}, s1_q.ma} * {{MW1{1'b0}}, s1_q.mb};
  end

  // Stage 3: normalize, round, range-check and pack.
  logic                  msb, g, st;
  logic [MAN_W-1:0]      frac_t, frac_f;
  logic signed [EW2-1:0] exp_n, exp_f;
`ifdef FPMUL_PIPE_RNE_EN
  logic                  inc, cout;
  logic [MAN_W-1:0]      frac_r;
`endif

  always_comb begin
    msb = s2_q.prod[PW-1];
    if (msb) begin
      frac_t = s2_q.prod[2*MAN_W:MAN_W+1];
      g      = s2_q.prod[MAN_W];
      st     = |s2_q.prod[MAN_W-1:0];
    end else begin
      frac_t = s2_q.prod[2*MAN_W-1:MAN_W];
      g      = s2_q.prod[MAN_W-1];
      st     = |s2_q.prod[MAN_W-2:0];
    end
    exp_n = s2_q.exp + $signed({{(EW2-1){1'b0}}, msb});
`ifdef FPMUL_PIPE_RNE_EN
    inc            = g & (st | frac_t[0]);
    {cout, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    frac_f         = cout ? '0 : frac_r;
    exp_f          = exp_n + $signed({{(EW2-1){1'b0}}, cout});
`else
    frac_f = frac_t;
    exp_f  = exp_n;
`endif
    s_d = '0;
    f_d = '0;
    case (s2_q.kind)
      K_NAN: begin
        s_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        f_d = {s2_q.inv, 3'b000};
      end
      K_INF:  s_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: s_d = {s2_q.sign, {(W-1){1'b0}}};
      default: begin
        if (exp_f >= EMAX) begin
          s_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          f_d = 4'b0101;
        end else if (exp_f[EW2-1] || exp_f == '0) begin
          s_d = {s2_q.sign, {(W-1){1'b0}}};
          f_d = 4'b0011;
        end else begin
          s_d = {s2_q.sign, exp_f[EXP_W-1:0], frac_f};
          f_d = {3'b000, g | st};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s_q        <= '0;
      f_q        <= '0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid)      s1_q <= s1_d;
      if (vld_pipe_q[1]) s2_q <= s2_d;
      if (vld_pipe_q[2]) begin
        s_q <= s_d;
        f_q <= f_d;
      end
    end
  end
endmodule
